vga_dac_out_pipe: RTL and testbench
===================================

// Module: vga_dac_out_pipe
// PURPOSE
//  Parametrised VGA colour output stage between the pixel generator and the PMOD VGA resistor DAC.
//  Converts IN_W-bit colour to OUT_W-bit DAC codes: truncation with optional 2x2 ordered (Bayer) dither, or MSB replication.
//  Delays colour, syncs and active_video by the same registered latency; forces blanking; applies per-sync polarity.
//  Tracks pixel, line and frame parity internally for the dither pattern.
// PARAMETERS
//  IN_W         8  input bits per colour channel (1..12)
//  OUT_W        4  DAC bits per colour channel (1..8)
//  PIPE_STAGES  2  latency in clk_i cycles, input to output, all outputs (1..4)
//  DITHER       1  1 = ordered dither when IN_W-OUT_W >= 2; otherwise plain truncation
//  HSYNC_POL    0  output hsync polarity: 1 = active-high, 0 = active-low
//  VSYNC_POL    0  output vsync polarity: 1 = active-high, 0 = active-low
// PORTS
//  clk_i           in   1      pixel clock
//  rst_ni          in   1      asynchronous active-low reset
//  en_i            in   1      0 = force colour to 0 (syncs still pass)
//  active_video_i  in   1      1 = visible pixel
//  r_i/g_i/b_i     in   IN_W   colour in
//  hsync_i         in   1      horizontal sync, active-high
//  vsync_i         in   1      vertical sync, active-high
//  vga_r_o/_g_o/_b_o out OUT_W DAC codes
//  hsync_o         out  1      hsync, polarity HSYNC_POL
//  vsync_o         out  1      vsync, polarity VSYNC_POL
//  active_video_o  out  1      active_video delayed PIPE_STAGES
//  frame_odd_o     out  1      current frame parity (debug)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): all pipeline regs clear; colours 0, active_video_o 0, syncs inactive
//    (POL=0 -> 1, POL=1 -> 0), x/y/frame parity 0. Takes effect immediately, mid-line included.
//  - Latency: input sampled at edge N appears on all outputs after edge N+PIPE_STAGES-1 (registered; no comb path in->out).
//  - Blanking: colour enters the pipe as 0 when active_video_i=0 or en_i=0 at its sample edge.
//  - Sync polarity applied at pipe output: out = POL ? sync : ~sync.
//  - Parity tracking (registered, updated every clk_i):
//    x_par: toggles each cycle active_video_i=1; cleared when active_video_i=0.
//    y_par: toggles on falling edge of active_video_i; cleared on rising edge of vsync_i.
//    f (frame_odd_o): toggles on rising edge of vsync_i.
//    Edges detected against a 1-cycle delayed copy of the input; rising vsync clear wins over line toggle.
//  - Conversion, D = IN_W-OUT_W:
//    D<=0: out = {in, in[IN_W-1 -: ...]} MSB-replicated to OUT_W (e.g. 4'b1011 -> 6'b101110).
//    D=1, or DITHER=0: out = in[IN_W-1 -: OUT_W].
//    D>=2 and DITHER=1: idx = {y_par^f, x_par^f}; t = idx 00:0, 01:2, 10:3, 11:1;
//      sum = in + (t << (D-2)) in IN_W+1 bits; if sum overflows IN_W, out = all-ones (saturate);
//      else out = sum[IN_W-1 -: OUT_W]. Same t for R, G, B.
//  - Parity values used are those held at the sample edge of the pixel (pre-update).
//  - No handshake: one pixel per cycle, no stall.
// TESTING
//  1 Reset mid-line, POL=0: drive r_i=8'hFF active, pull rst_ni low between edges -> vga_*_o=0,
//    hsync_o=vsync_o=1 immediately; release -> first valid pixel PIPE_STAGES cycles later.
//  2 Latency, PIPE_STAGES=2, DITHER=0: r_i=8'hAB and a 1-cycle hsync_i pulse in same cycle ->
//    vga_r_o=4'hA and hsync_o=0 together, exactly 2 edges later, 1 cycle wide.
//  3 Blanking: active_video_i=0 or en_i=0 with r_i=g_i=b_i=8'hFF -> all colours 0; syncs unaffected.
//  4 Dither, even frame, r_i=8'h07 constant: line0 x0,x1 -> 0,0; line1 x0,x1 -> 1,0.
//    r_i=8'hFF at t=3 -> 4'hF (saturated, no wrap).
//  5 Frame parity: r_i=8'h0C at line0 x0 -> 0 in even frame; after vsync_i rising edge -> 1, frame_odd_o=1.
//  6 Expansion, IN_W=4, OUT_W=6: r_i=4'b1011 -> vga_r_o=6'b101110; 4'hF -> 6'h3F; 4'h0 -> 6'h00.

Source files
------------

// File: rtl/vga_dac_out_pipe.sv
// ----------------------------------------------------------------------------
// vga_dac_out_pipe
//
// Colour output stage that sits between the pixel generator and a resistor
// ladder VGA DAC. It does four jobs:
//   - converts IN_W-bit colour to OUT_W-bit DAC codes by MSB replication,
//     truncation, or truncation with a 2x2 ordered (Bayer) dither;
//   - forces colour to zero outside the visible area or when disabled;
//   - delays colour, syncs and active_video by the same PIPE_STAGES cycles;
//   - applies the configured output polarity to each sync.
// Pixel, line and frame parity are tracked internally to select the dither
// threshold. The pipeline accepts one pixel per clock and never stalls.
//
// Ports
//   clk_i           in   1      pixel clock
//   rst_ni          in   1      asynchronous active-low reset
//   en_i            in   1      0 = force colour to 0 (syncs still pass)
//   active_video_i  in   1      1 = visible pixel
//   r_i/g_i/b_i     in   IN_W   colour in
//   hsync_i         in   1      horizontal sync, active-high
//   vsync_i         in   1      vertical sync, active-high
//   vga_r_o/g_o/b_o out  OUT_W  DAC codes
//   hsync_o         out  1      hsync, polarity HSYNC_POL
//   vsync_o         out  1      vsync, polarity VSYNC_POL
//   active_video_o  out  1      active_video delayed PIPE_STAGES cycles
//   frame_odd_o     out  1      current frame parity (debug)
// ----------------------------------------------------------------------------
module vga_dac_out_pipe #(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit DITHER      = 1'b1,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             active_video_i,
  input  logic [IN_W-1:0]  r_i,
  input  logic [IN_W-1:0]  g_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [OUT_W-1:0] vga_r_o,
  output logic [OUT_W-1:0] vga_g_o,
  output logic [OUT_W-1:0] vga_b_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             active_video_o,
  output logic             frame_odd_o
);

  // Bits dropped by the conversion; <= 0 means the DAC is at least as wide.
  localparam int D = IN_W - OUT_W;

  // --------------------------------------------------------------------------
  // Parity tracking for the dither pattern
  // --------------------------------------------------------------------------
  logic x_par_q, x_par_d;
  logic y_par_q, y_par_d;
  logic f_q,     f_d;
  logic av_dly_q, vs_dly_q;   // one-cycle delayed inputs for edge detection

  logic vs_rise, av_fall;
  assign vs_rise = vsync_i & ~vs_dly_q;
  assign av_fall = av_dly_q & ~active_video_i;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    x_par_d = active_video_i ? ~x_par_q : 1'b0;
    y_par_d = y_par_q;
    // A new frame restarts line counting even if a line ends in the same cycle.
    if (vs_rise) begin
      y_par_d = 1'b0;
    end else if (av_fall) begin
      y_par_d = ~y_par_q;
    end
    f_d = f_q ^ vs_rise;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_par_q  <= 1'b0;
      y_par_q  <= 1'b0;
      f_q      <= 1'b0;
      av_dly_q <= 1'b0;
      vs_dly_q <= 1'b0;
    end else begin
      x_par_q  <= x_par_d;
      y_par_q  <= y_par_d;
      f_q      <= f_d;
      av_dly_q <= active_video_i;
      vs_dly_q <= vsync_i;
    end
  end

  assign frame_odd_o = f_q;

  // --------------------------------------------------------------------------
  // Blanking and colour conversion (stage 0 next-state)
  // --------------------------------------------------------------------------
  logic                       blank;
  logic [2:0][IN_W-1:0]       rgb_in;
  logic [2:0][OUT_W-1:0]      rgb_d;

  assign blank  = ~(active_video_i & en_i);
  assign rgb_in = blank ? '0 : {b_i, g_i, r_i};

  if (D <= 0) begin : g_expand
    // Widen by repeating the input MSB-first until OUT_W bits are filled.
    always_comb begin
      rgb_d = '0;
      for (int ch = 0; ch < 3; ch++) begin
        for (int i = 0; i < OUT_W; i++) begin
          rgb_d[ch][OUT_W-1-i] = rgb_in[ch][IN_W-1-(i % IN_W)];
        end
      end
    end
  end else if (D == 1 || !DITHER) begin : g_trunc
    always_comb begin
      rgb_d = '0;
      for (int ch = 0; ch < 3; ch++) begin
        rgb_d[ch] = OUT_W'(rgb_in[ch] >> D);
      end
    end
  end else begin : g_dither
    localparam int SH = D - 2;

    // Frame parity flips the pattern phase so static images average out over
    // two frames as well as over a 2x2 block.
    logic [1:0] thr;
    always_comb begin
      unique case ({y_par_q ^ f_q, x_par_q ^ f_q})
        2'b00:   thr = 2'd0;
        2'b01:   thr = 2'd2;
        2'b10:   thr = 2'd3;
        default: thr = 2'd1;
      endcase
    end

    // One spare bit catches overflow; an overflowing sum saturates instead of
    // wrapping a bright pixel to black.
    always_comb begin
      logic [IN_W:0] sum;
      rgb_d = '0;
      sum   = '0;
      for (int ch = 0; ch < 3; ch++) begin
        sum = {1'b0, rgb_in[ch]} + ((IN_W+1)'(thr) << SH);
        rgb_d[ch] = sum[IN_W] ? '1 : OUT_W'(sum >> D);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Matched-latency pipeline
  // --------------------------------------------------------------------------
  // Syncs travel raw (active-high); polarity is applied after the last stage.
  logic [PIPE_STAGES-1:0][2:0][OUT_W-1:0] rgb_pipe_q;
  logic [PIPE_STAGES-1:0]                 hs_pipe_q;
  logic [PIPE_STAGES-1:0]                 vs_pipe_q;
  logic [PIPE_STAGES-1:0]                 av_pipe_q;

  // NOTE: the pipeline registers are reset on purpose: the DAC must show black
  // with inactive syncs the instant reset is asserted, even mid-line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      av_pipe_q  <= '0;
    end else begin
      rgb_pipe_q[0] <= rgb_d;
      hs_pipe_q[0]  <= hsync_i;
      vs_pipe_q[0]  <= vsync_i;
      av_pipe_q[0]  <= active_video_i;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        rgb_pipe_q[s] <= rgb_pipe_q[s-1];
        hs_pipe_q[s]  <= hs_pipe_q[s-1];
        vs_pipe_q[s]  <= vs_pipe_q[s-1];
        av_pipe_q[s]  <= av_pipe_q[s-1];
      end
    end
  end

  assign vga_r_o        = rgb_pipe_q[PIPE_STAGES-1][0];
  assign vga_g_o        = rgb_pipe_q[PIPE_STAGES-1][1];
  assign vga_b_o        = rgb_pipe_q[PIPE_STAGES-1][2];
  assign hsync_o        = HSYNC_POL ? hs_pipe_q[PIPE_STAGES-1] : ~hs_pipe_q[PIPE_STAGES-1];
  assign vsync_o        = VSYNC_POL ? vs_pipe_q[PIPE_STAGES-1] : ~vs_pipe_q[PIPE_STAGES-1];
  assign active_video_o = av_pipe_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_vga_dac_out_pipe.sv
// ----------------------------------------------------------------------------
// Bench for vga_dac_out_pipe. Three instances share the control inputs:
//   u_a: 8->4, 2 stages, dither on, active-low syncs
//   u_b: 8->4, 2 stages, dither off, active-low syncs
//   u_c: 4->6, 1 stage, expansion, active-high syncs
// A behavioural model (position counters and per-instance delay lines)
// predicts every output on every cycle; directed literal checks pin the
// model against hand-computed values.
// ----------------------------------------------------------------------------
module tb_vga_dac_out_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic en, av, hs, vs;
  logic [7:0] r8, g8, b8;
  logic [3:0] r4, g4, b4;

  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic [5:0] c_r, c_g, c_b;
  logic a_hs, a_vs, a_av, a_f;
  logic b_hs, b_vs, b_av, b_f;
  logic c_hs, c_vs, c_av, c_f;

  always #5 clk = ~clk;

  vga_dac_out_pipe #(.IN_W(8), .OUT_W(4), .PIPE_STAGES(2), .DITHER(1'b1),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .active_video_i(av),
    .r_i(r8), .g_i(g8), .b_i(b8), .hsync_i(hs), .vsync_i(vs),
    .vga_r_o(a_r), .vga_g_o(a_g), .vga_b_o(a_b), .hsync_o(a_hs), .vsync_o(a_vs),
    .active_video_o(a_av), .frame_odd_o(a_f));

  vga_dac_out_pipe #(.IN_W(8), .OUT_W(4), .PIPE_STAGES(2), .DITHER(1'b0),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .active_video_i(av),
    .r_i(r8), .g_i(g8), .b_i(b8), .hsync_i(hs), .vsync_i(vs),
    .vga_r_o(b_r), .vga_g_o(b_g), .vga_b_o(b_b), .hsync_o(b_hs), .vsync_o(b_vs),
    .active_video_o(b_av), .frame_odd_o(b_f));

  vga_dac_out_pipe #(.IN_W(4), .OUT_W(6), .PIPE_STAGES(1), .DITHER(1'b1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .active_video_i(av),
    .r_i(r4), .g_i(g4), .b_i(b4), .hsync_i(hs), .vsync_i(vs),
    .vga_r_o(c_r), .vga_g_o(c_g), .vga_b_o(c_b), .hsync_o(c_hs), .vsync_o(c_vs),
    .active_video_o(c_av), .frame_odd_o(c_f));

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  typedef struct {
    int r, g, b;
    bit hs, vs, av;   // syncs kept active-high, polarity applied at compare
  } exp_t;

  int   x_cnt, line_cnt, frame_cnt;
  bit   prev_av, prev_vs;
  exp_t pa[2], pb[2], pc[1];

  // Dither threshold from the position of the pixel on screen.
  function automatic int threshold(int x, int y, int f);
    int tbl[4] = '{0, 2, 3, 1};
    int idx;
    idx = (((y % 2) ^ (f % 2)) * 2) + ((x % 2) ^ (f % 2));
    return tbl[idx];
  endfunction

  function automatic int conv(int v, int iw, int ow, bit dith, int t);
    int d, s, o;
    d = iw - ow;
    o = 0;
    if (d <= 0) begin
      for (int i = 0; i < ow; i++) o = o * 2 + ((v >> (iw - 1 - (i % iw))) & 1);
    end else if (d == 1 || !dith) begin
      o = v / (1 << d);
    end else begin
      s = v + t * (1 << (d - 2));
      o = (s >= (1 << iw)) ? (1 << ow) - 1 : s / (1 << d);
    end
    return o;
  endfunction

  function automatic exp_t mk(int iw, int ow, bit dith, int t,
                              int r, int g, int b, bit vis);
    exp_t e;
    e.r  = conv(vis ? r : 0, iw, ow, dith, t);
    e.g  = conv(vis ? g : 0, iw, ow, dith, t);
    e.b  = conv(vis ? b : 0, iw, ow, dith, t);
    e.hs = hs;
    e.vs = vs;
    e.av = av;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t z;
    int   t;
    bit   vis;
    z = '{r: 0, g: 0, b: 0, hs: 1'b0, vs: 1'b0, av: 1'b0};
    if (!rst_n) begin
      x_cnt = 0; line_cnt = 0; frame_cnt = 0;
      prev_av = 1'b0; prev_vs = 1'b0;
      pa[0] = z; pa[1] = z; pb[0] = z; pb[1] = z; pc[0] = z;
    end else begin
      t   = threshold(x_cnt, line_cnt, frame_cnt);
      vis = av && en;
      pa[1] = pa[0];
      pa[0] = mk(8, 4, 1'b1, t, int'(r8), int'(g8), int'(b8), vis);
      pb[1] = pb[0];
      pb[0] = mk(8, 4, 1'b0, t, int'(r8), int'(g8), int'(b8), vis);
      pc[0] = mk(4, 6, 1'b1, t, int'(r4), int'(g4), int'(b4), vis);
      if (vs && !prev_vs) begin
        frame_cnt++;
        line_cnt = 0;
      end else if (prev_av && !av) begin
        line_cnt++;
      end
      x_cnt   = av ? x_cnt + 1 : 0;
      prev_av = av;
      prev_vs = vs;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_r", 32'(a_r), pa[1].r);  check("a_g", 32'(a_g), pa[1].g);
      check("a_b", 32'(a_b), pa[1].b);  check("a_hs", 32'(a_hs), 32'(!pa[1].hs));
      check("a_vs", 32'(a_vs), 32'(!pa[1].vs)); check("a_av", 32'(a_av), 32'(pa[1].av));
      check("b_r", 32'(b_r), pb[1].r);  check("b_g", 32'(b_g), pb[1].g);
      check("b_b", 32'(b_b), pb[1].b);  check("b_hs", 32'(b_hs), 32'(!pb[1].hs));
      check("b_vs", 32'(b_vs), 32'(!pb[1].vs)); check("b_av", 32'(b_av), 32'(pb[1].av));
      check("c_r", 32'(c_r), pc[0].r);  check("c_g", 32'(c_g), pc[0].g);
      check("c_b", 32'(c_b), pc[0].b);  check("c_hs", 32'(c_hs), 32'(pc[0].hs));
      check("c_vs", 32'(c_vs), 32'(pc[0].vs)); check("c_av", 32'(c_av), 32'(pc[0].av));
      check("a_frame", 32'(a_f), 32'(frame_cnt % 2));
      check("c_frame", 32'(c_f), 32'(frame_cnt % 2));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pix(input logic a, input logic [7:0] c);
    av = a; en = 1'b1;
    r8 = c; g8 = c; b8 = c >> 1;
    r4 = c[7:4]; g4 = c[7:4]; b4 = c[6:3];
    cyc();
  endtask

  task automatic vpulse();
    av = 1'b0; vs = 1'b1; cyc();
    vs = 1'b0; cyc();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; av = 1'b0; hs = 1'b0; vs = 1'b0;
    r8 = '0; g8 = '0; b8 = '0; r4 = '0; g4 = '0; b4 = '0;
    repeat (3) cyc();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Reset mid-line with full-scale colour on the wire.
    pix(1'b1, 8'hFF); pix(1'b1, 8'hFF); pix(1'b1, 8'hFF);
    check("t1_pre_a_r", 32'(a_r), 32'hF);
    check("t1_pre_b_r", 32'(b_r), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_a_r", 32'(a_r), 32'h0);
    check("t1_rst_b_r", 32'(b_r), 32'h0);
    check("t1_rst_a_hs", 32'(a_hs), 32'h1);
    check("t1_rst_a_vs", 32'(a_vs), 32'h1);
    check("t1_rst_c_hs", 32'(c_hs), 32'h0);
    check("t1_rst_c_r", 32'(c_r), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t1_rel1_b_r", 32'(b_r), 32'h0);
    check("t1_rel1_c_r", 32'(c_r), 32'h3F);
    cyc();
    check("t1_rel2_b_r", 32'(b_r), 32'hF);

    // Latency: colour and hsync pulse land together, two edges later.
    av = 1'b1; en = 1'b1; r8 = 8'hAB; g8 = 8'h12; b8 = 8'h34; hs = 1'b1;
    cyc();
    check("t2_early_b_hs", 32'(b_hs), 32'h1);
    hs = 1'b0; r8 = 8'h00;
    cyc();
    check("t2_b_r", 32'(b_r), 32'hA);
    check("t2_b_hs", 32'(b_hs), 32'h0);
    cyc();
    check("t2_after_b_hs", 32'(b_hs), 32'h1);

    // Blanking: en low, then active_video low; hsync must still pass.
    en = 1'b0; av = 1'b1; r8 = 8'hFF; g8 = 8'hFF; b8 = 8'hFF; hs = 1'b1;
    cyc();
    en = 1'b1; av = 1'b0; hs = 1'b0;
    cyc();
    check("t3_en_a_r", 32'(a_r), 32'h0);
    check("t3_en_a_g", 32'(a_g), 32'h0);
    check("t3_en_a_b", 32'(a_b), 32'h0);
    check("t3_en_a_hs", 32'(a_hs), 32'h0);
    cyc();
    check("t3_av_b_r", 32'(b_r), 32'h0);
    check("t3_av_a_g", 32'(a_g), 32'h0);
    check("t3_av_a_hs", 32'(a_hs), 32'h1);

    // Two vsync rises: back to an even frame with line parity cleared.
    av = 1'b0; vs = 1'b1; cyc();
    check("t5_frame_odd1", 32'(a_f), 32'h1);
    vs = 1'b0; cyc();
    vpulse();
    check("t5_frame_even", 32'(a_f), 32'h0);
    cyc();

    // Dither pattern, even frame, r=0x07.
    pix(1'b1, 8'h07);                              // line0 x0
    pix(1'b1, 8'h07);                              // line0 x1
    check("t4_l0x0", 32'(a_r), 32'h0);
    pix(1'b0, 8'h00);                              // end of line
    check("t4_l0x1", 32'(a_r), 32'h0);
    pix(1'b1, 8'h07);                              // line1 x0
    check("t4_blank", 32'(a_r), 32'h0);
    pix(1'b1, 8'h07);                              // line1 x1
    check("t4_l1x0", 32'(a_r), 32'h1);
    pix(1'b1, 8'hFF);                              // line1 x2, threshold 3
    check("t4_l1x1", 32'(a_r), 32'h0);
    pix(1'b0, 8'h00);
    check("t4_sat", 32'(a_r), 32'hF);

    // Frame parity: r=0x0C at line0 x0, even then odd frame.
    vpulse(); vpulse();
    pix(1'b1, 8'h0C);
    pix(1'b0, 8'h00);
    check("t5_even_r", 32'(a_r), 32'h0);
    vpulse();
    check("t5_frame_odd", 32'(a_f), 32'h1);
    pix(1'b1, 8'h0C);
    pix(1'b0, 8'h00);
    check("t5_odd_r", 32'(a_r), 32'h1);

    // Expansion 4 -> 6 with active-high hsync.
    av = 1'b1; en = 1'b1; r4 = 4'b1011; g4 = 4'hF; b4 = 4'h0; hs = 1'b1;
    cyc();
    check("t6_c_r", 32'(c_r), 32'b101110);
    check("t6_c_g", 32'(c_g), 32'h3F);
    check("t6_c_b", 32'(c_b), 32'h00);
    check("t6_c_hs", 32'(c_hs), 32'h1);
    hs = 1'b0; av = 1'b0;
    repeat (3) cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
